// File: rtl/branch_counter.sv
// Saturating up/down branch-prediction counter for one pattern-history-table slot.
// Define BRANCH_COUNTER_DEBUG_EN to expose cnt_state and enable internal checks.
module branch_counter #(
  parameter int CNT_WIDTH   = 2,
  parameter int RESET_VALUE = 2**(CNT_WIDTH-1)-1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 taken,
`ifdef BRANCH_COUNTER_DEBUG_EN
  output logic [CNT_WIDTH-1:0] cnt_state,
`endif
  output logic                 pred
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntRst = RESET_VALUE[CNT_WIDTH-1:0];

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Saturate at both ends so a run of identical outcomes never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      if (taken) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= CntRst;
    else       cnt_q <= cnt_d;
  end

  // Prediction comes from registered state only, so training lands one edge later.
  assign pred = cnt_q[CNT_WIDTH-1];

`ifdef BRANCH_COUNTER_DEBUG_EN
  assign cnt_state = cnt_q;

  if (CNT_WIDTH < 1 || CNT_WIDTH > 8) begin : g_bad_width
    $error("branch_counter: CNT_WIDTH out of range 1..8");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= 2**CNT_WIDTH) begin : g_bad_reset
    $error("branch_counter: RESET_VALUE does not fit in CNT_WIDTH bits");
  end

  always_ff @(posedge clock) begin
    assert (cnt_q <= CntMax);
    if (!reset && !wr_en) assert (cnt_d == cnt_q);
  end
`endif

endmodule

// File: tb/tb_branch_counter.sv
// Bench for branch_counter: widths 2, 3 and 1 driven in parallel and compared
// against an arithmetic model of the saturating counter.
module tb_branch_counter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic taken = 1'b0;
  logic pred2, pred3, pred1;
`ifdef BRANCH_COUNTER_DEBUG_EN
  logic [1:0] state2;
  logic [2:0] state3;
  logic [0:0] state1;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state per instance: index 0 = width 2, 1 = width 3, 2 = width 1.
  int widths[3] = '{2, 3, 1};
  int mcnt[3];

  always #5 clock = ~clock;

  branch_counter #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .taken(taken),
`ifdef BRANCH_COUNTER_DEBUG_EN
    .cnt_state(state2),
`endif
    .pred(pred2));

  branch_counter #(.CNT_WIDTH(3)) dut3 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .taken(taken),
`ifdef BRANCH_COUNTER_DEBUG_EN
    .cnt_state(state3),
`endif
    .pred(pred3));

  branch_counter #(.CNT_WIDTH(1)) dut1 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .taken(taken),
`ifdef BRANCH_COUNTER_DEBUG_EN
    .cnt_state(state1),
`endif
    .pred(pred1));

  function automatic void modelStep(input logic r, input logic w, input logic t);
    for (int i = 0; i < 3; i++) begin
      int maxv;
      maxv = (1 << widths[i]) - 1;
      if (r)           mcnt[i] = (1 << (widths[i] - 1)) - 1;
      else if (w && t) mcnt[i] = (mcnt[i] < maxv) ? mcnt[i] + 1 : maxv;
      else if (w)      mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
    end
  endfunction

  function automatic logic modelPred(input int i);
    return (mcnt[i] >= (1 << (widths[i] - 1)));
  endfunction

  task automatic checkBit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, " w2 pred"}, pred2, modelPred(0));
    checkBit({tag, " w3 pred"}, pred3, modelPred(1));
    checkBit({tag, " w1 pred"}, pred1, modelPred(2));
    checkVal({tag, " w2 cnt"}, int'(dut2.cnt_q), mcnt[0]);
    checkVal({tag, " w3 cnt"}, int'(dut3.cnt_q), mcnt[1]);
    checkVal({tag, " w1 cnt"}, int'(dut1.cnt_q), mcnt[2]);
`ifdef BRANCH_COUNTER_DEBUG_EN
    checkVal({tag, " w2 cnt_state"}, int'(state2), mcnt[0]);
    checkVal({tag, " w3 cnt_state"}, int'(state3), mcnt[1]);
    checkVal({tag, " w1 cnt_state"}, int'(state1), mcnt[2]);
`endif
  endtask

  // Drive at negedge, confirm pred ignores the new inputs until the edge, then check after it.
  task automatic applyStimulus(input string tag, input logic r, input logic w, input logic t);
    reset = r;
    wr_en = w;
    taken = t;
    #1;
    checkBit({tag, " pre-edge w2 pred"}, pred2, modelPred(0));
    @(posedge clock);
    modelStep(r, w, t);
    @(negedge clock);
    checkOutput(tag);
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1; wr_en = 1'b1; taken = 1'b1;
    @(posedge clock);
    modelStep(1'b1, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus("reset2", 1'b1, 1'b1, 1'b1);
    checkVal("reset w2 literal", int'(dut2.cnt_q), 1);
    checkVal("reset w3 literal", int'(dut3.cnt_q), 3);
    checkVal("reset w1 literal", int'(dut1.cnt_q), 0);
    checkBit("reset w2 pred literal", pred2, 1'b0);

    applyStimulus("up1", 1'b0, 1'b1, 1'b1);
    checkVal("up1 w2 literal", int'(dut2.cnt_q), 2);
    checkBit("up1 pred literal", pred2, 1'b1);
    applyStimulus("up2", 1'b0, 1'b1, 1'b1);
    checkVal("up2 w2 literal", int'(dut2.cnt_q), 3);
    applyStimulus("up3", 1'b0, 1'b1, 1'b1);
    checkVal("up3 w2 sat literal", int'(dut2.cnt_q), 3);
    applyStimulus("up4", 1'b0, 1'b1, 1'b1);
    checkVal("up4 w2 sat literal", int'(dut2.cnt_q), 3);
    checkVal("up4 w3 literal", int'(dut3.cnt_q), 7);

    applyStimulus("dn1", 1'b0, 1'b1, 1'b0);
    checkVal("dn1 w2 literal", int'(dut2.cnt_q), 2);
    checkBit("dn1 pred literal", pred2, 1'b1);
    applyStimulus("dn2", 1'b0, 1'b1, 1'b0);
    checkVal("dn2 w2 literal", int'(dut2.cnt_q), 1);
    checkBit("dn2 pred literal", pred2, 1'b0);
    applyStimulus("dn3", 1'b0, 1'b1, 1'b0);
    applyStimulus("dn4", 1'b0, 1'b1, 1'b0);
    checkVal("dn4 w2 sat literal", int'(dut2.cnt_q), 0);
    for (int i = 0; i < 5; i++) applyStimulus("dn-more", 1'b0, 1'b1, 1'b0);
    checkVal("dn w3 sat literal", int'(dut3.cnt_q), 0);

    for (int i = 0; i < 3; i++) applyStimulus("climb", 1'b0, 1'b1, 1'b1);
    applyStimulus("hyst-nt", 1'b0, 1'b1, 1'b0);
    checkBit("hyst-nt pred literal", pred2, 1'b1);
    applyStimulus("hyst-t", 1'b0, 1'b1, 1'b1);
    checkVal("hyst-t w2 literal", int'(dut2.cnt_q), 3);

    applyStimulus("to10", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("hold", 1'b0, 1'b0, i[0]);
    checkVal("hold w2 literal", int'(dut2.cnt_q), 2);
    checkBit("hold pred literal", pred2, 1'b1);

    applyStimulus("to11", 1'b0, 1'b1, 1'b1);
    applyStimulus("rst-mid", 1'b1, 1'b1, 1'b0);
    checkVal("rst-mid w2 literal", int'(dut2.cnt_q), 1);
    checkVal("rst-mid w3 literal", int'(dut3.cnt_q), 3);

    for (int i = 0; i < 400; i++) begin
      logic r, w, t;
      r = ($urandom_range(0, 24) == 0);
      w = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 99) < 60);
      applyStimulus("rand", r, w, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
